// File: rtl/pipe_intr_cp0_ctrl_pkg.sv
// Shared CP0 encodings: ExcCode values, mtc0 register selects, STATUS enable bits, FSM states.
package pipe_intr_cp0_ctrl_pkg;

  localparam logic [1:0] EXC_OV     = 2'b11;
  localparam logic [1:0] EXC_UNIMPL = 2'b10;
  localparam logic [1:0] EXC_SYS    = 2'b01;
  localparam logic [1:0] EXC_INTR   = 2'b00;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_STA  = 2'b01;
  localparam logic [1:0] SEL_CAU  = 2'b10;
  localparam logic [1:0] SEL_EPC  = 2'b11;

  localparam int STA_IE_INTR   = 0;
  localparam int STA_IE_SYS    = 1;
  localparam int STA_IE_UNIMPL = 2;
  localparam int STA_IE_OV     = 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } cp0_state_e;

endpackage

// File: rtl/pipe_intr_intr_sync.sv
// External interrupt front end: 2-FF synchronizer, rising-edge detect, pending latch.
module pipe_intr_intr_sync (
  input  logic clk,
  input  logic rst,
  input  logic intr,
  input  logic ack,
  output logic pending
);

  logic sync1_q, sync2_q, prev_q, pending_q;
  logic pending_d;

  // A held-high request produces exactly one rise, so only one acknowledge per assertion.
  always_comb begin
    pending_d = (sync2_q & ~prev_q) | (pending_q & ~ack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync1_q   <= intr;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/pipe_intr_cp0_ctrl.sv
// CP0 controller: STATUS/CAUSE/EPC, exception detect and priority for the EXE instruction,
// eret/mtc0 handling and a one-cycle RUN->FLUSH redirect FSM.
module pipe_intr_cp0_ctrl
  import pipe_intr_cp0_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_BASE = 32'h0000_0008,
  parameter logic [31:0] STA_RST  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        intr,
  output logic        inta,
  input  logic [31:0] e_pc,
  input  logic        e_bd,
  input  logic        e_ov,
  input  logic        e_arith,
  input  logic        e_sys,
  input  logic        e_unimpl,
  input  logic        e_eret,
  input  logic        e_mtc0,
  input  logic [1:0]  e_c0sel,
  input  logic [31:0] e_wdata,
  output logic [31:0] sta,
  output logic [31:0] cau,
  output logic [31:0] epc,
  output logic        cancel,
  output logic        redirect,
  output logic [31:0] pc_tgt,
  output logic        flush,
  output logic        state_dbg
);

  cp0_state_e  state_q, state_d;
  logic [31:0] sta_q, sta_d, cau_q, cau_d, epc_q, epc_d, pc_tgt_q, pc_tgt_d;
  logic        redirect_q, redirect_d;

  logic       pending;
  logic       ov_x, un_x, sy_x, in_x, any_x, run_ok;
  logic       exc, eret_take, mtc0_take;
  logic [1:0] code;

  pipe_intr_intr_sync u_intr_sync (
    .clk     (clk),
    .rst     (rst),
    .intr    (intr),
    .ack     (inta),
    .pending (pending)
  );

  always_comb begin
    ov_x   = e_ov & e_arith & sta_q[STA_IE_OV];
    un_x   = e_unimpl & sta_q[STA_IE_UNIMPL];
    sy_x   = e_sys & sta_q[STA_IE_SYS];
    in_x   = pending & sta_q[STA_IE_INTR];
    any_x  = ov_x | un_x | sy_x | in_x;
    run_ok = (state_q == ST_RUN) & ~stall;
    exc    = any_x & run_ok;
    if (ov_x)      code = EXC_OV;
    else if (un_x) code = EXC_UNIMPL;
    else if (sy_x) code = EXC_SYS;
    else           code = EXC_INTR;
    inta      = exc & ~ov_x & ~un_x & ~sy_x;
    eret_take = e_eret & run_ok & ~any_x;
    mtc0_take = e_mtc0 & run_ok & ~any_x;
    cancel    = exc | eret_take;
  end

  always_comb begin
    state_d    = state_q;
    sta_d      = sta_q;
    cau_d      = cau_q;
    epc_d      = epc_q;
    pc_tgt_d   = pc_tgt_q;
    redirect_d = redirect_q;
    case (state_q)
      ST_RUN: begin
        if (exc) begin
          // Exception in a delay slot restarts at the branch so the branch re-executes.
          epc_d      = e_bd ? (e_pc - 32'd4) : e_pc;
          cau_d      = {e_bd, 27'b0, code, 2'b00};
          sta_d      = {sta_q[27:0], 4'b0000};
          pc_tgt_d   = EXC_BASE;
          redirect_d = 1'b1;
          state_d    = ST_FLUSH;
        end else if (eret_take) begin
          sta_d      = {4'b0000, sta_q[31:4]};
          pc_tgt_d   = epc_q;
          redirect_d = 1'b1;
          state_d    = ST_FLUSH;
        end else if (mtc0_take) begin
          case (e_c0sel)
            SEL_STA: sta_d = e_wdata;
            SEL_CAU: cau_d = e_wdata;
            SEL_EPC: epc_d = e_wdata;
            default: ;
          endcase
        end
      end
      ST_FLUSH: begin
        if (!stall) begin
          redirect_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      default: begin
        redirect_d = 1'b0;
        state_d    = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      sta_q      <= STA_RST;
      cau_q      <= 32'h0;
      epc_q      <= 32'h0;
      pc_tgt_q   <= 32'h0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sta_q      <= sta_d;
      cau_q      <= cau_d;
      epc_q      <= epc_d;
      pc_tgt_q   <= pc_tgt_d;
      redirect_q <= redirect_d;
    end
  end

  assign sta       = sta_q;
  assign cau       = cau_q;
  assign epc       = epc_q;
  assign pc_tgt    = pc_tgt_q;
  assign redirect  = redirect_q;
  assign flush     = redirect_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pipe_intr_cp0_ctrl.sv
// Directed bench for pipe_intr_cp0_ctrl: inputs driven after the falling edge, outputs sampled there.
module tb_pipe_intr_cp0_ctrl;

  logic        clk, rst, stall, intr, inta;
  logic [31:0] e_pc;
  logic        e_bd, e_ov, e_arith, e_sys, e_unimpl, e_eret, e_mtc0;
  logic [1:0]  e_c0sel;
  logic [31:0] e_wdata, sta, cau, epc, pc_tgt;
  logic        cancel, redirect, flush, state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  pipe_intr_cp0_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .intr(intr), .inta(inta),
    .e_pc(e_pc), .e_bd(e_bd), .e_ov(e_ov), .e_arith(e_arith), .e_sys(e_sys),
    .e_unimpl(e_unimpl), .e_eret(e_eret), .e_mtc0(e_mtc0), .e_c0sel(e_c0sel),
    .e_wdata(e_wdata), .sta(sta), .cau(cau), .epc(epc), .cancel(cancel),
    .redirect(redirect), .pc_tgt(pc_tgt), .flush(flush), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    stall = 1'b0; e_pc = 32'h0; e_bd = 1'b0; e_ov = 1'b0; e_arith = 1'b0;
    e_sys = 1'b0; e_unimpl = 1'b0; e_eret = 1'b0; e_mtc0 = 1'b0;
    e_c0sel = 2'b00; e_wdata = 32'h0;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_c0(input logic [1:0] sel, input logic [31:0] data);
    idle();
    e_mtc0 = 1'b1; e_c0sel = sel; e_wdata = data;
    cycle();
    idle();
  endtask

  task automatic do_eret();
    idle();
    e_eret = 1'b1;
    #1 check("eret_cancel", 32'(cancel), 32'd1);
    cycle();
    idle();
  endtask

  initial begin
    idle();
    intr = 1'b0;
    rst  = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    #1;
    check("rst_sta", sta, 32'h0);
    check("rst_cau", cau, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_pc_tgt", pc_tgt, 32'h0);
    check("rst_inta", 32'(inta), 32'd0);

    // 1: overflow trap
    write_c0(2'b01, 32'h0000_0008);
    check("t1_sta_wr", sta, 32'h8);
    e_arith = 1'b1; e_ov = 1'b1; e_pc = 32'h100;
    #1 check("t1_cancel", 32'(cancel), 32'd1);
    check("t1_inta", 32'(inta), 32'd0);
    cycle(); idle();
    check("t1_epc", epc, 32'h100);
    check("t1_cau", cau, 32'h0000_000C);
    check("t1_sta", sta, 32'h80);
    check("t1_redirect", 32'(redirect), 32'd1);
    check("t1_flush", 32'(flush), 32'd1);
    check("t1_pc_tgt", pc_tgt, 32'h8);
    check("t1_state", 32'(state_dbg), 32'd1);
    cycle();
    check("t1_redirect_drop", 32'(redirect), 32'd0);
    check("t1_state_run", 32'(state_dbg), 32'd0);

    // 2: syscall in delay slot, stall during FLUSH, then eret
    write_c0(2'b01, 32'h0000_000F);
    e_sys = 1'b1; e_bd = 1'b1; e_pc = 32'h204;
    cycle(); idle();
    check("t2_epc", epc, 32'h200);
    check("t2_cau", cau, 32'h8000_0004);
    check("t2_sta", sta, 32'hF0);
    stall = 1'b1;
    cycle();
    check("t2_stall_hold", 32'(redirect), 32'd1);
    stall = 1'b0;
    cycle();
    check("t2_flush_done", 32'(redirect), 32'd0);
    do_eret();
    check("t2_eret_tgt", pc_tgt, 32'h200);
    check("t2_eret_sta", sta, 32'hF);
    check("t2_eret_redir", 32'(redirect), 32'd1);
    cycle();

    // 3: external interrupt, 3-edge latency, single acknowledge
    e_pc = 32'h300;
    intr = 1'b1;
    cycle();
    check("t3_inta_e1", 32'(inta), 32'd0);
    cycle();
    check("t3_inta_e2", 32'(inta), 32'd0);
    cycle();
    check("t3_inta_e3", 32'(inta), 32'd1);
    check("t3_cancel", 32'(cancel), 32'd1);
    cycle(); idle();
    check("t3_inta_gone", 32'(inta), 32'd0);
    check("t3_cau", cau, 32'h0);
    check("t3_epc", epc, 32'h300);
    check("t3_sta", sta, 32'hF0);
    cycle();
    do_eret();
    check("t3_sta_pop", sta, 32'hF);
    cycle();
    for (int i = 0; i < 4; i++) begin
      check("t3_no_second_inta", 32'(inta), 32'd0);
      cycle();
    end
    intr = 1'b0;
    cycle(); cycle(); cycle();

    // 4: pending interrupt loses to unimplemented, taken after eret
    stall = 1'b1;
    intr  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_stall_no_inta", 32'(inta), 32'd0);
    end
    stall = 1'b0; e_unimpl = 1'b1; e_pc = 32'h500;
    #1 check("t4_cancel", 32'(cancel), 32'd1);
    check("t4_inta_unimpl", 32'(inta), 32'd0);
    cycle(); idle();
    check("t4_cau", cau, 32'h8);
    check("t4_sta", sta, 32'hF0);
    check("t4_epc", epc, 32'h500);
    check("t4_inta_flush", 32'(inta), 32'd0);
    cycle();
    check("t4_inta_masked", 32'(inta), 32'd0);
    do_eret();
    check("t4_sta_pop", sta, 32'hF);
    check("t4_inta_in_flush", 32'(inta), 32'd0);
    cycle();
    check("t4_inta_after_eret", 32'(inta), 32'd1);
    cycle();
    intr = 1'b0;
    check("t4_cau_intr", cau, 32'h0);
    check("t4_epc_intr", epc, 32'h0);
    cycle();

    // 5: mtc0 under stall, select decoding, and losing to an exception
    idle();
    e_mtc0 = 1'b1; e_c0sel = 2'b11; e_wdata = 32'h400; stall = 1'b1;
    cycle();
    check("t5_epc_stalled", epc, 32'h0);
    stall = 1'b0;
    cycle(); idle();
    check("t5_epc_written", epc, 32'h400);
    write_c0(2'b10, 32'h0000_1234);
    check("t5_cau_written", cau, 32'h1234);
    write_c0(2'b01, 32'h0000_0008);
    write_c0(2'b00, 32'hDEAD_BEEF);
    check("t5_sel0_sta", sta, 32'h8);
    check("t5_sel0_cau", cau, 32'h1234);
    check("t5_sel0_epc", epc, 32'h400);
    e_mtc0 = 1'b1; e_c0sel = 2'b01; e_wdata = 32'h55;
    e_ov = 1'b1; e_arith = 1'b1; e_pc = 32'h600;
    #1 check("t5_cancel", 32'(cancel), 32'd1);
    cycle(); idle();
    check("t5_sta_exc", sta, 32'h80);
    check("t5_cau_exc", cau, 32'hC);
    check("t5_epc_exc", epc, 32'h600);

    // 6: reset during FLUSH abandons the redirect
    check("t6_in_flush", 32'(redirect), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_redirect", 32'(redirect), 32'd0);
    check("t6_flush", 32'(flush), 32'd0);
    check("t6_sta", sta, 32'h0);
    check("t6_cau", cau, 32'h0);
    check("t6_epc", epc, 32'h0);
    check("t6_pc_tgt", pc_tgt, 32'h0);

    // masked sources and priority encoding
    e_sys = 1'b1;
    #1 check("mask_sys_cancel", 32'(cancel), 32'd0);
    idle();
    write_c0(2'b01, 32'h0000_0006);
    e_sys = 1'b1; e_unimpl = 1'b1; e_ov = 1'b1; e_arith = 1'b1; e_pc = 32'h700;
    cycle(); idle();
    check("prio_cau", cau, 32'h8);
    check("prio_sta", sta, 32'h60);
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
